// File: rtl/uart_delay_cfg_rx.sv
// UART receiver and 64-bit configuration-frame decoder that drives per-channel delay-RAM write strobes.
// Define UART_RX_PARITY_EN to expect and check an even-parity bit after data bit 7 of every byte.
module uart_delay_cfg_rx #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 11,
  parameter int DELAY_W      = 24,
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_rxb,
  input  logic [3:0]                I_ga,
  output logic [NUM_CH-1:0]         O_wea,
  output logic [NUM_CH*ADDR_W-1:0]  O_waddr,
  output logic [NUM_CH*DELAY_W-1:0] O_wdelay,
  output logic                      O_frame_ok,
  output logic [2:0]                O_err
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_LIM + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic               rx_s1, rx_s2, rx_d;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic [2:0]         byte_cnt;
  logic [TW-1:0]      to_cnt;
  logic [7:0]         cmd_r;
  logic [3:0]         ga_r, ch_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DELAY_W-1:0] dly_r;
  logic [DELAY_W-1:0] dly_full;
  logic [NUM_CH-1:0]  sel;
  logic               accept;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`endif

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= I_rxb;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Channel 0xF selects every channel; otherwise channel c maps to index c-1.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      sel[k] = (ch_r == 4'hF) || (ch_r == 4'(k + 1));
  end

  assign accept   = (cmd_r == 8'h02) && ((ga_r == I_ga) || (ga_r == 4'hF)) && (|sel);
  assign dly_full = DELAY_W'({dly_r, shreg});

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      cmd_r      <= '0;
      ga_r       <= '0;
      ch_r       <= '0;
      addr_r     <= '0;
      dly_r      <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
      O_wea      <= '0;
      O_waddr    <= '0;
      O_wdelay   <= '0;
      O_frame_ok <= 1'b0;
      O_err      <= '0;
    end else begin
      O_wea      <= '0;
      O_frame_ok <= 1'b0;
      O_err      <= '0;

      // Inter-byte gap is only measured while idle inside a partially received frame.
      if (byte_cnt == 3'd0 || state != S_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TO_LIM)) begin
        O_err[1] <= 1'b1;
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s2) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PAR;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bit <= rx_s2;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (!rx_s2) begin
              O_err[0] <= 1'b1;
              byte_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            end else if (par_bit != ^shreg) begin
              O_err[2] <= 1'b1;
              byte_cnt <= '0;
`endif
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              case (byte_cnt)
                3'd0: cmd_r <= shreg;
                3'd2: addr_r <= ADDR_W'(shreg);
                3'd3: addr_r <= ADDR_W'({addr_r, shreg});
                3'd4: {ga_r, ch_r} <= shreg;
                3'd5: dly_r <= DELAY_W'(shreg);
                3'd6: dly_r <= dly_full;
                3'd7: begin
                  if (accept) begin
                    O_wea      <= sel;
                    O_frame_ok <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                      if (sel[k]) begin
                        O_waddr[k*ADDR_W +: ADDR_W]    <= addr_r;
                        O_wdelay[k*DELAY_W +: DELAY_W] <= dly_full;
                      end
                    end
                  end
                end
                default: ;
              endcase
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_delay_cfg_rx.sv
// Directed bench for uart_delay_cfg_rx with a scoreboard of expected strobe/error events.
module tb_uart_delay_cfg_rx;

  localparam int NCH = 4;
  localparam int AW  = 11;
  localparam int DW  = 24;
  localparam int CPB = 16;
  localparam int TOB = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rxb = 1'b1;
  logic [3:0]          ga  = 4'd14;
  logic [NCH-1:0]      wea;
  logic [NCH*AW-1:0]   waddr;
  logic [NCH*DW-1:0]   wdelay;
  logic                frame_ok;
  logic [2:0]          err;

  uart_delay_cfg_rx #(
    .NUM_CH(NCH), .ADDR_W(AW), .DELAY_W(DW), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_rxb(rxb), .I_ga(ga),
    .O_wea(wea), .O_waddr(waddr), .O_wdelay(wdelay), .O_frame_ok(frame_ok), .O_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] wea;
    logic [2:0]     err;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dly;
  } ev_t;

  ev_t           q[$];
  ev_t           mon_e;
  logic [AW-1:0] m_addr [NCH];
  logic [DW-1:0] m_dly  [NCH];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec-level decode: pushes an expected write event if the frame is accepted.
  task automatic model_frame(input logic [63:0] f);
    logic [NCH-1:0] s;
    ev_t            e;
    s = '0;
    for (int k = 0; k < NCH; k++)
      if (f[27:24] == 4'hF || int'(f[27:24]) == k + 1) s[k] = 1'b1;
    if (f[63:56] == 8'h02 && (f[31:28] == ga || f[31:28] == 4'hF) && s != 0) begin
      e.wea  = s;
      e.err  = 3'b000;
      e.addr = f[32 +: AW];
      e.dly  = f[0 +: DW];
      q.push_back(e);
      for (int k = 0; k < NCH; k++)
        if (s[k]) begin
          m_addr[k] = f[32 +: AW];
          m_dly[k]  = f[0 +: DW];
        end
    end
  endtask

  task automatic expect_err(input int b);
    ev_t e;
    e.wea  = '0;
    e.err  = 3'b000;
    e.err[b] = 1'b1;
    e.addr = '0;
    e.dly  = '0;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rxb = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    rxb = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ bad_par);
`endif
    send_bit(!bad_stop);
    if (bad_stop) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [63:0] f, input int bad_stop_idx, input int bad_par_idx);
    for (int i = 0; i < 8; i++)
      send_byte(f[63-8*i -: 8], i == bad_stop_idx, i == bad_par_idx);
  endtask

  function automatic logic [NCH*AW-1:0] pack_addr();
    logic [NCH*AW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*AW +: AW] = m_addr[k];
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] pack_dly();
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = m_dly[k];
    return v;
  endfunction

  // Scoreboard consumer: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (wea != 0 || frame_ok || err != 0)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {wea, frame_ok, err}, 0);
      end else begin
        mon_e = q.pop_front();
        check("wea", wea, mon_e.wea);
        check("frame_ok", frame_ok, mon_e.wea != 0);
        check("err", err, mon_e.err);
        for (int k = 0; k < NCH; k++)
          if (mon_e.wea[k]) begin
            check("waddr", waddr[k*AW +: AW], mon_e.addr);
            check("wdelay", wdelay[k*DW +: DW], mon_e.dly);
          end
      end
    end
  end

  initial begin
    logic [63:0] f;
    for (int k = 0; k < NCH; k++) begin
      m_addr[k] = '0;
      m_dly[k]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_wea", wea, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_err", err, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdelay", wdelay, 0);
    rst = 1'b0;
    idle(2);

    // Four unicast writes, sent back to back.
    for (int d = 1; d <= 4; d++) begin
      f = {32'h02002000, 4'hE, 4'(d), 24'(d * 10)};
      model_frame(f);
      send_frame(f, -1, -1);
    end
    idle(2);
    check("unicast_delays", wdelay, {24'd40, 24'd30, 24'd20, 24'd10});
    check("unicast_addrs", waddr, 0);

    // Rejected frames: wrong GA, channel out of range, non-write CMD.
    f = {32'h02002000, 4'h3, 4'h1, 24'h000055}; model_frame(f); send_frame(f, -1, -1);
    f = {32'h02002000, 4'hE, 4'h5, 24'h000066}; model_frame(f); send_frame(f, -1, -1);
    f = {32'h01002000, 4'hE, 4'h1, 24'h000077}; model_frame(f); send_frame(f, -1, -1);
    idle(2);
    check("rejects_hold", wdelay, {24'd40, 24'd30, 24'd20, 24'd10});

    // Broadcast to all channels.
    f = {32'h02000005, 4'hF, 4'hF, 24'h000123};
    model_frame(f);
    send_frame(f, -1, -1);
    idle(2);
    check("bcast_addr", waddr, {NCH{11'd5}});
    check("bcast_dly", wdelay, {NCH{24'h000123}});

    // Framing error on byte 3, then one byte and a stall long enough to time out.
    f = {32'h02000123, 4'hE, 4'h2, 24'h00ABCD};
    expect_err(0);
    for (int i = 0; i < 3; i++) send_byte(f[63-8*i -: 8], i == 2, 1'b0);
    send_byte(f[31:24], 1'b0, 1'b0);
    expect_err(1);
    idle(40);
    model_frame(f);
    send_frame(f, -1, -1);
    idle(2);
    check("after_err_dly", wdelay, pack_dly());

    // Reset in the middle of byte 5.
    f = {32'h02000077, 4'hE, 4'h3, 24'h000333};
    for (int i = 0; i < 4; i++) send_byte(f[63-8*i -: 8], 1'b0, 1'b0);
    rxb = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      m_addr[k] = '0;
      m_dly[k]  = '0;
    end
    repeat (5) @(negedge clk);
    check("midrst_wea", wea, 0);
    check("midrst_waddr", waddr, 0);
    check("midrst_wdelay", wdelay, 0);
    check("midrst_ok_err", {frame_ok, err}, 0);
    rxb = 1'b1;
    rst = 1'b0;
    idle(2);
    model_frame(f);
    send_frame(f, -1, -1);
    idle(2);
    check("postrst_addr", waddr, pack_addr());
    check("postrst_dly", wdelay, pack_dly());

`ifdef UART_RX_PARITY_EN
    // Bad parity on byte 7; the trailing byte 8 then starts a new frame that times out.
    f = {32'h02000011, 4'hE, 4'h4, 24'h000444};
    expect_err(2);
    send_frame(f, -1, 6);
    expect_err(1);
    idle(40);
    f = {32'h02000022, 4'hE, 4'h4, 24'h000555};
    model_frame(f);
    send_frame(f, -1, -1);
    idle(2);
`endif

    idle(3);
    check("pending_events", q.size(), 0);
    check("final_addr", waddr, pack_addr());
    check("final_dly", wdelay, pack_dly());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
